// File: rtl/trap_ctrl.sv
// trap_ctrl -- machine-mode trap sequencer.
//
// Takes exceptions, mret and enabled machine interrupts. Each one runs a fixed
// sequence of writes through the single CSR write port and then issues one
// fetch redirect. Requests that arrive outside IDLE are dropped, not queued.
//
// Optional feature macro: TRAP_VECTORED_EN
//   When defined and mtvec[1:0]==2'b01, interrupts redirect to
//   base + 4*cause[3:0]. Exceptions always use the base address.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   exc_req/cause/pc/tval     exception pulse and its payload from execute
//   mret_req                  mret pulse
//   irq_ext, irq_timer        level interrupt pending lines
//   irq_pc                    return address for interrupts
//   csr_mstatus/mie/mtvec/mepc current CSR values
//   csr_we/waddr/wdata        CSR write port (addr/data are 0 when we=0)
//   flush                     one-cycle pipeline flush at sequence start
//   busy                      sequence in progress
//   redirect_valid/pc         one-cycle fetch redirect
// All outputs are registered.
module trap_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        exc_req,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic [31:0] irq_pc,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mie,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] W_EPC   = 3'd1;
  localparam logic [2:0] W_CAUSE = 3'd2;
  localparam logic [2:0] W_TVAL  = 3'd3;
  localparam logic [2:0] W_STAT  = 3'd4;
  localparam logic [2:0] M_STAT  = 3'd5;
  localparam logic [2:0] REDIR   = 3'd6;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  logic [2:0]  state;
  logic [31:0] cause_q, tval_q;

  // IDLE arbitration: exception > mret > external irq > timer irq
  logic        take_trap, take_mret;
  logic [31:0] t_cause, t_epc, t_tval;

  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    t_cause   = 32'h0;
    t_epc     = 32'h0;
    t_tval    = 32'h0;
    if (exc_req) begin
      take_trap = 1'b1;
      t_cause   = {28'b0, exc_cause};
      t_epc     = exc_pc;
      t_tval    = exc_tval;
    end else if (mret_req) begin
      take_mret = 1'b1;
    end else if (irq_ext & csr_mie[11] & csr_mstatus[3]) begin
      take_trap = 1'b1;
      t_cause   = 32'h8000000B;
      t_epc     = irq_pc;
    end else if (irq_timer & csr_mie[7] & csr_mstatus[3]) begin
      take_trap = 1'b1;
      t_cause   = 32'h80000007;
      t_epc     = irq_pc;
    end
  end

  // mstatus on trap entry: MPIE<-MIE, MIE<-0, MPP<-M
  logic [31:0] stat_trap, stat_mret;
  always_comb begin
    stat_trap        = csr_mstatus;
    stat_trap[7]     = csr_mstatus[3];
    stat_trap[3]     = 1'b0;
    stat_trap[12:11] = 2'b11;
    stat_mret        = csr_mstatus;
    stat_mret[3]     = csr_mstatus[7];
    stat_mret[7]     = 1'b1;
    stat_mret[12:11] = 2'b11;
  end

  logic [31:0] trap_tgt;
  always_comb begin
    trap_tgt = {csr_mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (csr_mtvec[1:0] == 2'b01 && cause_q[31])
      trap_tgt = {csr_mtvec[31:2], 2'b00} + {26'b0, cause_q[3:0], 2'b00};
`else
    trap_tgt = {csr_mtvec[31:2], 2'b00};
`endif
  end

  // Outputs are registered: each transition loads the outputs of the state
  // being entered, so they appear in the cycle that state occupies.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cause_q        <= 32'h0;
      tval_q         <= 32'h0;
      csr_we         <= 1'b0;
      csr_waddr      <= 12'h0;
      csr_wdata      <= 32'h0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      csr_we         <= 1'b0;
      csr_waddr      <= 12'h0;
      csr_wdata      <= 32'h0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      case (state)
        IDLE: begin
          if (take_trap) begin
            state     <= W_EPC;
            cause_q   <= t_cause;
            tval_q    <= t_tval;
            csr_we    <= 1'b1;
            csr_waddr <= A_MEPC;
            csr_wdata <= {t_epc[31:2], 2'b00};
            flush     <= 1'b1;
            busy      <= 1'b1;
          end else if (take_mret) begin
            state     <= M_STAT;
            csr_we    <= 1'b1;
            csr_waddr <= A_MSTATUS;
            csr_wdata <= stat_mret;
            flush     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        W_EPC: begin
          state     <= W_CAUSE;
          csr_we    <= 1'b1;
          csr_waddr <= A_MCAUSE;
          csr_wdata <= cause_q;
        end
        W_CAUSE: begin
          state     <= W_TVAL;
          csr_we    <= 1'b1;
          csr_waddr <= A_MTVAL;
          csr_wdata <= tval_q;
        end
        W_TVAL: begin
          state     <= W_STAT;
          csr_we    <= 1'b1;
          csr_waddr <= A_MSTATUS;
          csr_wdata <= stat_trap;
        end
        W_STAT: begin
          state          <= REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_tgt;
        end
        M_STAT: begin
          state          <= REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= csr_mepc;
        end
        REDIR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Bits of the inputs this block never looks at
  logic unused_ok;
  assign unused_ok = &{1'b0, csr_mie, csr_mtvec[1:0], exc_pc[1:0], irq_pc[1:0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: checks outputs on the falling edge, one
// directed step after another, and models the CSR file only as far as
// updating mstatus when the sequencer writes it.
module tb_trap_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        exc_req, mret_req, irq_ext, irq_timer;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, irq_pc;
  logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
  logic        csr_we, flush, busy, redirect_valid;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .rstn(rstn),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_req(mret_req), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_pc(irq_pc),
    .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .flush(flush), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  // Pack {flush,busy,redirect_valid,csr_we} for compact control checks
  function automatic logic [31:0] ctl();
    return {28'b0, flush, busy, redirect_valid, csr_we};
  endfunction

  task automatic chk_wr(input string tag, input logic [11:0] a, input logic [31:0] d);
    chk({tag, "_we"},   {31'b0, csr_we}, 32'h1);
    chk({tag, "_addr"}, {20'b0, csr_waddr}, {20'b0, a});
    chk({tag, "_data"}, csr_wdata, d);
  endtask

  // Full trap sequence. Call with the request already driven before edge T.
  task automatic trap_seq(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] stat,
                          input logic [31:0] tgt, input logic drop_irq);
    cyc;  // T+1
    exc_req = 1'b0; mret_req = 1'b0;
    if (drop_irq) begin irq_ext = 1'b0; irq_timer = 1'b0; end
    chk({tag, "_t1_ctl"}, ctl(), 32'b1101);
    chk_wr({tag, "_epc"}, 12'h341, epc);
    cyc;  // T+2
    chk({tag, "_t2_ctl"}, ctl(), 32'b0101);
    chk_wr({tag, "_cause"}, 12'h342, cause);
    cyc;  // T+3
    chk_wr({tag, "_tval"}, 12'h343, tval);
    cyc;  // T+4
    chk_wr({tag, "_stat"}, 12'h300, stat);
    csr_mstatus = stat;  // CSR file takes the write at the end of this cycle
    cyc;  // T+5
    chk({tag, "_t5_ctl"}, ctl(), 32'b0110);
    chk({tag, "_t5_addr"}, {20'b0, csr_waddr}, 32'h0);
    chk({tag, "_t5_data"}, csr_wdata, 32'h0);
    chk({tag, "_rpc"}, redirect_pc, tgt);
    cyc;  // T+6
    chk({tag, "_t6_ctl"}, ctl(), 32'b0000);
  endtask

  logic [31:0] vec_tgt;

  initial begin
    rstn = 1'b0;
    exc_req = 0; mret_req = 0; irq_ext = 0; irq_timer = 0;
    exc_cause = 0; exc_pc = 0; exc_tval = 0; irq_pc = 0;
    csr_mstatus = 0; csr_mie = 0; csr_mtvec = 0; csr_mepc = 0;
    cyc; cyc;
    chk("rst_ctl", ctl(), 32'h0);
    chk("rst_addr", {20'b0, csr_waddr}, 32'h0);
    chk("rst_data", csr_wdata, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    rstn = 1'b1;
    cyc;
    chk("idle_ctl", ctl(), 32'h0);

    // ecall
    csr_mstatus = 32'h8; csr_mtvec = 32'h200;
    exc_req = 1; exc_cause = 4'd11; exc_pc = 32'h100; exc_tval = 32'h0;
    trap_seq("ecall", 32'h100, 32'hB, 32'h0, 32'h1880, 32'h200, 1'b0);

    // mret
    csr_mstatus = 32'h1880; csr_mepc = 32'h104; mret_req = 1;
    cyc;
    mret_req = 0;
    chk("mret_t1_ctl", ctl(), 32'b1101);
    chk_wr("mret_stat", 12'h300, 32'h1888);
    csr_mstatus = 32'h1888;
    cyc;
    chk("mret_t2_ctl", ctl(), 32'b0110);
    chk("mret_rpc", redirect_pc, 32'h104);
    cyc;
    chk("mret_t3_ctl", ctl(), 32'b0000);

    // Timer interrupt, deasserted right after acceptance
    csr_mstatus = 32'h8; csr_mie = 32'h80; csr_mtvec = 32'h200;
    irq_pc = 32'h40; irq_timer = 1;
    trap_seq("tmr", 32'h40, 32'h80000007, 32'h0, 32'h1880, 32'h200, 1'b1);

    // Timer pending but MIE clear: nothing happens
    csr_mstatus = 32'h0; irq_timer = 1;
    cyc; cyc; cyc;
    chk("tmr_off_ctl", ctl(), 32'h0);
    irq_timer = 0;

    // Exception + mret + external irq together; misaligned pc gets aligned
    csr_mstatus = 32'h8; csr_mie = 32'h800; irq_ext = 1; mret_req = 1;
    exc_req = 1; exc_cause = 4'd2; exc_pc = 32'h206; exc_tval = 32'hDEADBEEF;
    trap_seq("sim", 32'h204, 32'h2, 32'hDEADBEEF, 32'h1880, 32'h200, 1'b0);
    cyc; cyc;
    chk("sim_noirq_ctl", ctl(), 32'h0);
    irq_ext = 0;

    // External interrupt with vectored mtvec
`ifdef TRAP_VECTORED_EN
    vec_tgt = 32'h22C;
`else
    vec_tgt = 32'h200;
`endif
    csr_mstatus = 32'h8; csr_mtvec = 32'h201; csr_mie = 32'h800;
    irq_pc = 32'h80; irq_ext = 1;
    trap_seq("vec", 32'h80, 32'h8000000B, 32'h0, 32'h1880, vec_tgt, 1'b1);

    // Reset in W_CAUSE
    csr_mstatus = 32'h8; csr_mtvec = 32'h200;
    exc_req = 1; exc_cause = 4'd11; exc_pc = 32'h100; exc_tval = 32'h0;
    cyc;
    exc_req = 0;
    cyc;
    chk_wr("rmid_cause", 12'h342, 32'hB);
    rstn = 1'b0;
    #1;
    chk("rmid_ctl", ctl(), 32'h0);
    chk("rmid_addr", {20'b0, csr_waddr}, 32'h0);
    chk("rmid_data", csr_wdata, 32'h0);
    cyc;
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc;
      chk("rmid_quiet", ctl(), 32'h0);
    end
    exc_req = 1;
    trap_seq("fresh", 32'h100, 32'hB, 32'h0, 32'h1880, 32'h200, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
